// File: rtl/ula_pkg.sv
// Shared constants and types for the ALU command sequencer.
package ula_pkg;

  localparam int OPW  = 3;
  localparam int RESW = 6;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic           chain;
    logic [OPW-1:0] op;
    logic [OPW-1:0] b;
    logic [OPW-1:0] a;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Saturating increment for the 4-bit error counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/ula_if.sv
// Command and result handshake bundle between the input logic, the sequencer
// and the display logic.
interface ula_if;

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [ula_pkg::OPW-1:0]     cmd_a;
  logic [ula_pkg::OPW-1:0]     cmd_b;
  logic [ula_pkg::OPW-1:0]     cmd_op;
  logic                        cmd_chain;

  logic                        res_valid;
  logic                        res_ready;
  logic [ula_pkg::RESW-1:0]    res_data;
  logic                        res_zero;
  logic                        res_neg;
  logic                        res_ovf;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain, res_ready,
    input  cmd_ready, res_valid, res_data, res_zero, res_neg, res_ovf
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain, res_ready,
    output cmd_ready, res_valid, res_data, res_zero, res_neg, res_ovf
  );

endinterface

// File: rtl/ula_cmd_fifo.sv
// Synchronous command FIFO; full/empty derive from registered occupancy only,
// so they carry no combinational path from push/pop.
module ula_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset because occupancy guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ula_ctrl.sv
// ALU command sequencer: queues commands, issues one at a time to the external
// combinational ALU and holds each result until the consumer takes it.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | nothing issued; pop and load the ALU as soon as a command waits
//   EXEC    | ALU inputs registered and settling; capture on the next edge
//   DONE    | result presented; on handshake issue the next command or idle
module ula_ctrl
  import ula_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ula_if.slave            bus,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [RESW-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            alu_neg,
  input  logic            alu_ovf,
  output logic            busy,
  output logic [3:0]      div_err_cnt
);

  state_t            state;
  state_t            state_nxt;
  logic              pop;
  logic              capture;
  logic              full;
  logic              empty;
  logic [CMD_W-1:0]  fifo_wdata;
  logic [CMD_W-1:0]  fifo_rdata;
  cmd_t              head;
  logic [RESW-1:0]   last_res;

  assign fifo_wdata    = {bus.cmd_chain, bus.cmd_op, bus.cmd_b, bus.cmd_a};
  assign head          = cmd_t'(fifo_rdata);
  assign bus.cmd_ready = !full;
  assign bus.res_valid = (state == ST_DONE);
  assign busy          = (state != ST_IDLE) || !empty;

  ula_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cmd_valid),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state, pop and capture strobes.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        capture   = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = ST_EXEC;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ALU drive registers; chained commands take A from the previous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else if (pop) begin
      alu_a  <= head.chain ? last_res[OPW-1:0] : head.a;
      alu_b  <= head.b;
      alu_op <= head.op;
    end
  end

  // Result capture and divide-by-zero counter, updated only on EXEC exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_data <= '0;
      bus.res_zero <= 1'b0;
      bus.res_neg  <= 1'b0;
      bus.res_ovf  <= 1'b0;
      last_res     <= '0;
      div_err_cnt  <= '0;
    end else if (capture) begin
      bus.res_data <= alu_result;
      bus.res_zero <= alu_zero;
      bus.res_neg  <= alu_neg;
      bus.res_ovf  <= alu_ovf;
      last_res     <= alu_result;
      if (alu_op == OP_DIV && alu_b == '0) div_err_cnt <= sat_inc4(div_err_cnt);
    end
  end

endmodule

// File: tb/tb_ula_ctrl.sv
// Bench for ula_ctrl with a behavioural ALU attached and a result scoreboard.
module tb_ula_ctrl;
  import ula_pkg::*;

  typedef struct packed {
    logic [5:0] data;
    logic       z;
    logic       n;
    logic       o;
  } res_t;

  typedef struct packed {
    res_t       r;
    logic [3:0] err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] alu_a, alu_b, alu_op;
  logic [5:0] alu_result;
  logic       alu_zero, alu_neg, alu_ovf;
  logic       busy;
  logic [3:0] div_err_cnt;

  ula_if bus ();

  ula_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .alu_neg     (alu_neg),
    .alu_ovf     (alu_ovf),
    .busy        (busy),
    .div_err_cnt (div_err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: unsigned 3-bit operands, 6-bit result, negative = bit 5,
  // overflow only on divide by zero, reserved opcode returns all ones.
  function automatic res_t alu_fn(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op);
    logic [5:0] r;
    logic       o;
    o = 1'b0;
    case (op)
      OP_ADD: r = {3'b0, a} + {3'b0, b};
      OP_SUB: r = {3'b0, a} - {3'b0, b};
      OP_MUL: r = {3'b0, a} * {3'b0, b};
      OP_DIV: if (b == 3'd0) begin r = 6'd0; o = 1'b1; end
              else r = {3'b0, a / b};
      OP_AND: r = {3'b0, a & b};
      OP_OR:  r = {3'b0, a | b};
      OP_XOR: r = {3'b0, a ^ b};
      default: r = 6'h3F;
    endcase
    return '{data: r, z: (r == 6'd0), n: r[5], o: o};
  endfunction

  always_comb {alu_result, alu_zero, alu_neg, alu_ovf} = alu_fn(alu_a, alu_b, alu_op);

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  logic [5:0] m_last;
  int   m_err;
  res_t last_seen;
  int   n_results = 0;
  bit   spacing_en = 0;
  int   last_hs = -1;
  bit   hold = 0;
  logic [8:0] hold_val;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: commands complete in acceptance order, so each result
  // can be computed at acceptance from the model's own running last result.
  task automatic model_accept(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                              input logic chain);
    logic [2:0] a_eff;
    res_t r;
    a_eff  = chain ? m_last[2:0] : a;
    r      = alu_fn(a_eff, b, op);
    m_last = r.data;
    if (op == OP_DIV && b == 3'd0 && m_err < 15) m_err++;
    exp_q.push_back('{r: r, err: 4'(m_err)});
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last = 6'd0;
    m_err  = 0;
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                      input logic chain);
    bit ok;
    ok = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_chain = chain;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (bus.cmd_ready) begin
        @(posedge clk);
        model_accept(a, b, op, chain);
        ok = 1;
      end else begin
        @(posedge clk);
      end
      #1;
    end
    bus.cmd_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy) done = 1;
    end
    if (!done) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic random_cmd(output logic [2:0] a, output logic [2:0] b, output logic [2:0] op,
                            output logic chain);
    a     = 3'($urandom_range(0, 7));
    b     = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
    op    = 3'($urandom_range(0, 7));
    chain = 1'($urandom_range(0, 1));
  endtask

  // Monitor: score every handshake and check that held results stay stable.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold = 0;
    end else begin
      if (hold) begin
        check("hold_valid", bus.res_valid, 1);
        check("hold_data", {bus.res_data, bus.res_zero, bus.res_neg, bus.res_ovf}, hold_val);
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("res_data", bus.res_data, e.r.data);
          check("res_flags", {bus.res_zero, bus.res_neg, bus.res_ovf}, {e.r.z, e.r.n, e.r.o});
          check("div_err_cnt", div_err_cnt, e.err);
          last_seen = '{data: bus.res_data, z: bus.res_zero, n: bus.res_neg, o: bus.res_ovf};
          n_results++;
          if (spacing_en && last_hs >= 0) check("spacing", cyc - last_hs, 2);
          last_hs = cyc;
        end
      end
      hold     = bus.res_valid && !bus.res_ready;
      hold_val = {bus.res_data, bus.res_zero, bus.res_neg, bus.res_ovf};
    end
  end

  initial begin
    logic [2:0] ra, rb, rop;
    logic       rch;
    int         acc;
    int         seen;
    int         n0;
    bit         rnd_done;

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
    bus.cmd_chain = 1'b0; bus.res_ready = 1'b0;
    model_reset();

    // Reset state
    #12;
    check("rst_alu", {alu_a, alu_b, alu_op}, 0);
    check("rst_res", {bus.res_valid, bus.res_data, bus.res_zero, bus.res_neg, bus.res_ovf}, 0);
    check("rst_busy_err", {busy, div_err_cnt}, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with latency check
    bus.res_ready = 1'b1;
    send(3'd3, 3'd3, OP_ADD, 1'b0);
    check("lat_t0_valid", bus.res_valid, 0);
    @(posedge clk); #1;
    check("lat_t1_valid", bus.res_valid, 0);
    @(posedge clk); #1;
    check("lat_t2_valid", bus.res_valid, 1);
    check("add_data", bus.res_data, 6);
    check("add_flags", {bus.res_zero, bus.res_neg, bus.res_ovf}, 3'b000);
    wait_idle();

    // Chain: 2*3 = 6, then chained (A=6) 6-1 = 5
    send(3'd2, 3'd3, OP_MUL, 1'b0);
    send(3'd7, 3'd1, OP_SUB, 1'b1);
    wait_idle();
    check("chain_result", last_seen.data, 5);

    // Divide by zero and counter saturation
    send(3'd5, 3'd0, OP_DIV, 1'b0);
    wait_idle();
    check("div0_data", last_seen.data, 0);
    check("div0_zero_ovf", {last_seen.z, last_seen.o}, 2'b11);
    check("div0_cnt", div_err_cnt, 1);
    for (int i = 0; i < 16; i++) send(3'd5, 3'd0, OP_DIV, 1'b0);
    wait_idle();
    check("div0_sat", div_err_cnt, 15);

    // Backpressure: 7 offers, 5 accepted
    bus.res_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      bit took;
      random_cmd(ra, rb, rop, rch);
      bus.cmd_valid = 1'b1;
      bus.cmd_a = ra; bus.cmd_b = rb; bus.cmd_op = rop; bus.cmd_chain = rch;
      took = bus.cmd_ready;
      @(posedge clk);
      if (took) begin acc++; model_accept(ra, rb, rop, rch); end
      #1;
    end
    bus.cmd_valid = 1'b0;
    check("bp_accepted", acc, 5);
    check("bp_cmd_ready", bus.cmd_ready, 0);
    n0 = n_results;
    spacing_en = 1; last_hs = -1;
    wait_idle();
    spacing_en = 0;
    check("bp_results", n_results - n0, 5);
    check("bp_busy", busy, 0);

    // Randomized traffic with random result backpressure
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          random_cmd(ra, rb, rop, rch);
          send(ra, rb, rop, rch);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    wait_idle();

    // Reset while in EXEC with 3 entries queued
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(3'(i + 1), 3'd1, OP_ADD, 1'b0);
    check("mid_full", bus.cmd_ready, 0);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("mid_in_exec", {bus.res_valid, busy}, 2'b01);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_alu", {alu_a, alu_b, alu_op}, 0);
    check("mid_rst_res", {bus.res_valid, bus.res_data, bus.res_zero, bus.res_neg, bus.res_ovf}, 0);
    check("mid_rst_busy_err", {busy, div_err_cnt}, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    bus.res_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.res_valid || busy) seen++;
    end
    check("post_rst_quiet", seen, 0);

    // Recovery after reset; chained A must come from the cleared last result
    send(3'd1, 3'd2, OP_ADD, 1'b0);
    wait_idle();
    check("post_rst_add", last_seen.data, 3);
    rst_n = 1'b0; #1; model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    send(3'd7, 3'd4, OP_ADD, 1'b1);
    wait_idle();
    check("post_rst_chain", last_seen.data, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ula_ctrl.md
# ula_ctrl

Command sequencer for the 3-bit ALU. It accepts operation commands over a valid/ready interface and buffers them in a small FIFO. It then issues them one at a time to the combinational ALU through registered operand/opcode outputs, captures the ALU result and flags, and presents them on a valid/ready result port. It sits between the switch/button input logic and the display/LED logic; the top level instantiates this block and the ALU side by side and wires `alu_*` between them.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: command FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; equals `!full`, with no combinational path from any input.
- `cmd_a`, `cmd_b`  in  3 each  operands.
- `cmd_op`  in  3  ALU opcode.
- `cmd_chain`  in  1  1: use the previous result's bits [2:0] as A and ignore `cmd_a`.
- `alu_a`, `alu_b`, `alu_op`  out  3 each  registered drive to the ALU.
- `alu_result`  in  6  ALU result.
- `alu_zero`, `alu_neg`, `alu_ovf`  in  1 each  ALU flags.
- `res_valid`  out  1  captured result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  6  captured result.
- `res_zero`, `res_neg`, `res_ovf`  out  1 each  captured flags.
- `busy`  out  1  high when the state is not IDLE or the FIFO is non-empty.
- `div_err_cnt`  out  4  count of issued ops with opcode 011 and B=0; saturates at 15.

## Operation

- FSM states: IDLE, EXEC, DONE.
- **IDLE:**
  - If the FIFO is non-empty: pop one entry.
  - Load `alu_a` = (chain ? `last_res[2:0]` : a), `alu_b`, `alu_op`.
  - Go to EXEC.
- **EXEC:**
  - The ALU output has settled.
  - Capture `alu_result` and the three flags into `res_*` and `last_res` (6 bits).
  - If op==011 and `alu_b`==0, increment `div_err_cnt` (saturating).
  - Go to DONE.
- **DONE:**
  - `res_valid`=1. Outputs are held stable until the handshake.
  - On `res_valid & res_ready`: if the FIFO is non-empty, pop and load the ALU registers in the same edge and go to EXEC; otherwise go to IDLE.
- The opcode is passed through unchanged. Reserved opcode 111 is issued normally; its result is whatever the ALU returns.
- `alu_*` hold their last values while in IDLE and DONE.
- Chain uses `last_res` as it stands at pop time. Because pop always follows the previous capture, a chained command sees the immediately preceding result. `last_res` resets to 0.
- FIFO boundaries:
  - Push when full is impossible (`cmd_ready`=0).
  - Push and pop in the same cycle are both performed; the count is unchanged.
  - Push into an empty FIFO has no bypass; the entry is poppable the next cycle.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Reset at any time:
  - FIFO emptied, state IDLE.
  - All outputs 0: `alu_*`, `res_*`, `res_valid`, `busy`, `div_err_cnt`, `last_res`.
  - `cmd_ready`=1.
  - An in-flight command or result is discarded.

## Timing

- Command accepted at edge T: pop and ALU register load at edge T+1; capture at T+2; `res_valid` high from T+2 onward.
- Steady-state throughput: one result per 2 cycles when `res_ready` is held at 1.
- `res_*` and the flags change only on the EXEC→DONE edge.
- `cmd_ready` reflects the FIFO occupancy after the previous edge.

## Structure

- Package `ula_pkg` contains:
  - opcode constants (ADD=000, SUB=001, MUL=010, DIV=011, AND=100, OR=101, XOR=110, RSV=111);
  - state enum;
  - width constants (operand 3, result 6);
  - command struct {chain, op, b, a}.
- Sub-module `ula_cmd_fifo`: synchronous FIFO parameterised on depth and width, with full/empty, same `clk`/`rst_n`.
- FSM, chain mux, capture registers and error counter live in `ula_ctrl`.

## Test plan

Benches attach a behavioural ALU model.

- **ADD:** A=3, B=3, op=000, `res_ready`=1 → `res_valid` 2 cycles after the accept edge. `res_data`=6; the flags equal the model's.
- **Chain:** cmd1 A=2, B=3, op=010 (MUL); cmd2 chain=1, `cmd_a`=7, B=1, op=001 (SUB) → results 6 then 5 (cmd2 uses A=6, not 7).
- **Divide by zero:** A=5, B=0, op=011 → `res_data`=0, `res_zero`=1, `res_ovf`=1, `div_err_cnt`=1. Sixteen more such commands → `div_err_cnt` holds at 15.
- **Backpressure:** `res_ready`=0, offer 7 back-to-back commands → 5 accepted (1 in flight + 4 queued) and `cmd_ready`=0. Then raise `res_ready` → 5 results in order, spaced 2 cycles apart, then IDLE with `busy`=0.
- **Reset mid-operation:** assert `rst_n`=0 while in EXEC with 3 entries queued → all outputs 0 immediately, `cmd_ready`=1. After release, no `res_valid` appears without new commands.
